// File: rtl/direct_mapped_cache_if.sv
// Processor-side and memory-side signal bundle for direct_mapped_cache.
// master = processor/slow_memory side, slave = the cache itself.
interface direct_mapped_cache_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/direct_mapped_cache.sv
// Direct-mapped write-back/write-allocate cache with stall-on-miss refill FSM.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module direct_mapped_cache #(
    parameter int LINES      = 8,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    direct_mapped_cache_if.slave  bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        dirty_q;
    logic [TAG_W-1:0]        tag_arr  [LINES];
    logic [LINE_WIDTH-1:0]   data_arr [LINES];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [TAG_W-1:0] tag;
    logic             req;
    logic             hit;
    logic             stall;
    logic             mem_rd;
    logic             mem_wr;
    logic [27:0]      mem_addr;

    assign idx = bus.proc_addr[IDX_W+1:2];
    assign off = bus.proc_addr[1:0];
    assign tag = bus.proc_addr[29:IDX_W+2];
    assign req = bus.proc_read | bus.proc_write;
    assign hit = valid_q[idx] && (tag_arr[idx] == tag);

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = bus.proc_addr[29:2];
        case (state_q)
            COMPARE: begin
                if (req && !hit) begin
                    stall   = 1'b1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                // Request drops as soon as mem_ready is seen so memory never relaunches.
                stall    = 1'b1;
                mem_wr   = !bus.mem_ready;
                mem_addr = {tag_arr[idx], idx};
                if (bus.mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                stall  = 1'b1;
                mem_rd = !bus.mem_ready;
                if (bus.mem_ready) state_d = COMPARE;
            end
            default: state_d = COMPARE;
        endcase
        if (proc_reset) begin
            stall  = 1'b0;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    assign bus.proc_stall = stall;
    assign bus.mem_read   = mem_rd;
    assign bus.mem_write  = mem_wr;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = data_arr[idx];
    assign bus.proc_rdata = data_arr[idx][{off, 5'b0} +: 32];

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= COMPARE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == COMPARE && bus.proc_write && hit) dirty_q[idx] <= 1'b1;
            if (state_q == ALLOCATE && bus.mem_ready) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag/data storage is never cleared; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (state_q == COMPARE && bus.proc_write && hit)
            data_arr[idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
        if (state_q == ALLOCATE && bus.mem_ready) begin
            data_arr[idx] <= bus.mem_rdata;
            tag_arr[idx]  <= tag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic refill_done_q;

    // The first COMPARE cycle after a refill completes a miss, not a new hit.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            refill_done_q <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            refill_done_q <= (state_q == ALLOCATE) && bus.mem_ready;
            if (state_q == COMPARE && req) begin
                if (!hit)                miss_cnt <= miss_cnt + 32'd1;
                else if (!refill_done_q) hit_cnt  <= hit_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed bench for direct_mapped_cache: refill, hits, write-back, reset mid-miss.
// Counter checks are included when CACHE_PERF_CNT_EN is defined.
module tb_direct_mapped_cache;
    logic clk = 1'b0;
    logic proc_reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    direct_mapped_cache_if bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    direct_mapped_cache #(.LINES(8), .LINE_WIDTH(128)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] WA = 32'h1111_AAAA, WB = 32'h2222_BBBB;
    localparam logic [31:0] WC = 32'h3333_CCCC, WD = 32'h4444_DDDD;
    localparam logic [31:0] WE = 32'h5555_EEEE, WF = 32'h6666_FFFF;
    localparam logic [31:0] WG = 32'h7777_0707, WH = 32'h8888_0808;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        proc_reset         = 1'b1;
        bus.proc_read      = 1'b1;
        bus.proc_write     = 1'b0;
        bus.proc_addr      = 30'h10;
        bus.proc_wdata     = '0;
        bus.mem_rdata      = '0;
        bus.mem_ready      = 1'b0;

        // Reset with a request pending: outputs stay quiet
        @(negedge clk);
        chk("rst_stall", bus.proc_stall, 1'b0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
`ifdef CACHE_PERF_CNT_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();
        proc_reset = 1'b0;

        // Test 1: cold miss on 0x10, refill with {D,C,B,A}
        @(negedge clk);
        chk("t1_cmp_stall", bus.proc_stall, 1'b1);
        chk("t1_cmp_mem_read", bus.mem_read, 1'b0);
        tick();
        @(negedge clk);
        chk("t1_alloc_stall", bus.proc_stall, 1'b1);
        chk("t1_alloc_mem_read", bus.mem_read, 1'b1);
        chk("t1_alloc_mem_write", bus.mem_write, 1'b0);
        chk("t1_alloc_mem_addr", bus.mem_addr, 28'h4);
        bus.mem_rdata = {WD, WC, WB, WA};
        bus.mem_ready = 1'b1;
        #1;
        chk("t1_ready_drops_read", bus.mem_read, 1'b0);
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t1_done_stall", bus.proc_stall, 1'b0);
        chk("t1_done_rdata", bus.proc_rdata, WA);
        chk("t1_done_mem_read", bus.mem_read, 1'b0);
        tick();

        // Test 2: hit on neighbouring word
        bus.proc_addr = 30'h11;
        @(negedge clk);
        chk("t2_stall", bus.proc_stall, 1'b0);
        chk("t2_rdata", bus.proc_rdata, WB);
        chk("t2_mem_read", bus.mem_read, 1'b0);
        chk("t2_mem_write", bus.mem_write, 1'b0);
        tick();

        // Test 3: write hit then read back
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b1;
        bus.proc_addr  = 30'h12;
        bus.proc_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t3_wr_stall", bus.proc_stall, 1'b0);
        tick();
        bus.proc_write = 1'b0;
        bus.proc_read  = 1'b1;
        @(negedge clk);
        chk("t3_rd_stall", bus.proc_stall, 1'b0);
        chk("t3_rd_rdata", bus.proc_rdata, 32'hDEAD_BEEF);
        tick();

        // Test 4: conflict miss on dirty line -> writeback then refill
        bus.proc_addr = 30'h112;
        @(negedge clk);
        chk("t4_cmp_stall", bus.proc_stall, 1'b1);
        chk("t4_cmp_mem_write", bus.mem_write, 1'b0);
        tick();
        @(negedge clk);
        chk("t4_wb_mem_write", bus.mem_write, 1'b1);
        chk("t4_wb_mem_read", bus.mem_read, 1'b0);
        chk("t4_wb_mem_addr", bus.mem_addr, 28'h4);
        chk("t4_wb_wdata_w2", bus.mem_wdata[95:64], 32'hDEAD_BEEF);
        chk("t4_wb_wdata", bus.mem_wdata, {WD, 32'hDEAD_BEEF, WB, WA});
        tick();
        @(negedge clk);
        chk("t4_wb_hold_write", bus.mem_write, 1'b1);
        chk("t4_wb_hold_addr", bus.mem_addr, 28'h4);
        bus.mem_ready = 1'b1;
        #1;
        chk("t4_wb_ready_drops", bus.mem_write, 1'b0);
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t4_alloc_mem_read", bus.mem_read, 1'b1);
        chk("t4_alloc_mem_write", bus.mem_write, 1'b0);
        chk("t4_alloc_mem_addr", bus.mem_addr, 28'h44);
        chk("t4_alloc_stall", bus.proc_stall, 1'b1);
        bus.mem_rdata = {WH, WG, WF, WE};
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t4_done_stall", bus.proc_stall, 1'b0);
        chk("t4_done_rdata", bus.proc_rdata, WG);
        tick();
        bus.proc_read = 1'b0;
        @(negedge clk);
        chk("idle_stall", bus.proc_stall, 1'b0);
`ifdef CACHE_PERF_CNT_EN
        chk("t6_hit_cnt", hit_cnt, 32'd3);
        chk("t6_miss_cnt", miss_cnt, 32'd2);
`endif
        tick();

        // Test 5: reset during ALLOCATE, stale ready afterwards
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h20;
        @(negedge clk);
        chk("t5_cmp_stall", bus.proc_stall, 1'b1);
        tick();
        @(negedge clk);
        chk("t5_alloc_mem_read", bus.mem_read, 1'b1);
        chk("t5_alloc_mem_addr", bus.mem_addr, 28'h8);
        proc_reset = 1'b1;
        #1;
        chk("t5_rst_mem_read", bus.mem_read, 1'b0);
        chk("t5_rst_stall", bus.proc_stall, 1'b0);
`ifdef CACHE_PERF_CNT_EN
        chk("t5_rst_hit_cnt", hit_cnt, 32'd0);
        chk("t5_rst_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();
        proc_reset    = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("t5_stale_stall", bus.proc_stall, 1'b1);
        chk("t5_stale_mem_read", bus.mem_read, 1'b0);
        chk("t5_stale_mem_write", bus.mem_write, 1'b0);
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t5_remiss_mem_read", bus.mem_read, 1'b1);
        chk("t5_remiss_mem_addr", bus.mem_addr, 28'h8);
        bus.mem_rdata = {WH, WG, WF, WE};
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t5_done_stall", bus.proc_stall, 1'b0);
        chk("t5_done_rdata", bus.proc_rdata, WE);
        tick();

        // Reset also invalidated the line at index 4; its dirty bit is gone too
        bus.proc_addr = 30'h112;
        @(negedge clk);
        chk("t5_inv_stall", bus.proc_stall, 1'b1);
        tick();
        @(negedge clk);
        chk("t5_inv_mem_read", bus.mem_read, 1'b1);
        chk("t5_inv_mem_write", bus.mem_write, 1'b0);
        chk("t5_inv_mem_addr", bus.mem_addr, 28'h44);
        bus.proc_read = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
